sg_read_req_sequencer: RTL and testbench

- Consumes scatter-gather elements (64-bit byte address, 32-bit word length) from the SG list reader.
- Splits each element into bus read requests that respect a maximum read size and an address-boundary limit, until a programmed transfer length has been requested.
- Sits between the SG list reader and the read-request TLP formatter in the RX channel path, and is the only block that pops elements from the reader.

---
 rtl/sg_pkg.sv | 33 +++
 rtl/sg_req_len_calc.sv | 58 +++++
 rtl/sg_read_req_sequencer.sv | 231 +++++++++++++++++++++++
 tb/tb_sg_read_req_sequencer.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/sg_pkg.sv
// ---------------------------------------------------------------------------
// sg_pkg
// Shared definitions for the scatter-gather read-request sequencer:
//   - sg_state_t     : sequencer FSM states
//   - SG_WORD_SHIFT  : shift converting a 32-bit word count to a byte count
//   - SG_REQ_LEN_W   : width of the request length field
//   - SG_ADDR_W      : width of an SG element / request byte address
//   - SG_LEN_W       : width of an SG element length and of transfer counters
//   - min_len()      : unsigned minimum of two length values
// ---------------------------------------------------------------------------
package sg_pkg;

    localparam int SG_WORD_SHIFT = 2;
    localparam int SG_REQ_LEN_W  = 10;
    localparam int SG_ADDR_W     = 64;
    localparam int SG_LEN_W      = 32;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WAIT_ELEM = 3'd1,
        ST_CALC      = 3'd2,
        ST_ISSUE     = 3'd3,
        ST_FIN       = 3'd4
    } sg_state_t;

    function automatic logic [SG_LEN_W-1:0] min_len(
        input logic [SG_LEN_W-1:0] a,
        input logic [SG_LEN_W-1:0] b
    );
        return (a < b) ? a : b;
    endfunction

endpackage

// File: rtl/sg_req_len_calc.sv
// ---------------------------------------------------------------------------
// sg_req_len_calc
// Combinational length of the next read request: the minimum of the words
// left in the element, the words left in the transfer, the maximum read size
// and the words remaining before the next address boundary.
// Ports:
//   addr     in  64  current (word-aligned) byte address
//   elem_rem in  32  words left in the current element
//   xfer_rem in  32  words left in the transfer
//   req_len  out 10  request length in words
// ---------------------------------------------------------------------------
module sg_req_len_calc
    import sg_pkg::*;
#(
    parameter int C_MAX_READ_WORDS = 128,
    parameter int C_BOUNDARY_WORDS = 1024
) (
    input  logic [SG_ADDR_W-1:0]    addr,
    input  logic [SG_LEN_W-1:0]     elem_rem,
    input  logic [SG_LEN_W-1:0]     xfer_rem,
    output logic [SG_REQ_LEN_W-1:0] req_len
);

    localparam int BOUND_BITS = $clog2(C_BOUNDARY_WORDS);

    logic [SG_LEN_W-1:0] room_words;
    logic [SG_LEN_W-1:0] min_data;
    logic [SG_LEN_W-1:0] min_max;
    logic [SG_LEN_W-1:0] min_all;

    // Words left before the boundary: boundary size minus the word offset
    // of the address inside its boundary-sized window.
    generate
        if (BOUND_BITS == 0) begin : g_no_boundary
            logic unused_addr;
            assign room_words  = SG_LEN_W'(1);
            assign unused_addr = ^addr;
        end else begin : g_boundary
            logic [BOUND_BITS-1:0] word_offset;
            logic                  unused_addr;
            assign word_offset = addr[BOUND_BITS+SG_WORD_SHIFT-1:SG_WORD_SHIFT];
            assign room_words  = SG_LEN_W'(C_BOUNDARY_WORDS) - SG_LEN_W'(word_offset);
            assign unused_addr = ^{addr[SG_ADDR_W-1:BOUND_BITS+SG_WORD_SHIFT],
                                   addr[SG_WORD_SHIFT-1:0]};
        end
    endgenerate

    assign min_data = min_len(elem_rem, xfer_rem);
    assign min_max  = min_len(min_data, SG_LEN_W'(C_MAX_READ_WORDS));
    assign min_all  = min_len(min_max, room_words);

    // The result never exceeds C_MAX_READ_WORDS (<= 512), so it fits 10 bits.
    assign req_len = min_all[SG_REQ_LEN_W-1:0];

    logic unused_len_hi;
    assign unused_len_hi = ^min_all[SG_LEN_W-1:SG_REQ_LEN_W];

endmodule

// File: rtl/sg_read_req_sequencer.sv
// ---------------------------------------------------------------------------
// sg_read_req_sequencer
// Pops scatter-gather elements from the SG list reader and splits them into
// bus read requests bounded by the maximum read size and the address
// boundary, until the programmed transfer length has been requested.
// Ports:
//   CLK, RST_N             clock, asynchronous active-low reset
//   START, XFER_LEN        begin a transfer of XFER_LEN words (idle only)
//   ABORT                  abandon the current transfer
//   BUSY, DONE             transfer in progress / one-cycle end pulse
//   WORDS_REQD             words acknowledged so far in this transfer
//   SG_VALID, SG_EMPTY     reader element valid / reader empty (unused)
//   SG_REN                 one-cycle pop of the current element
//   SG_ADDR, SG_LEN        element byte address and word length
//   REQ, REQ_ACK           read request handshake
//   REQ_ADDR, REQ_LEN      request byte address and word length
// ---------------------------------------------------------------------------
module sg_read_req_sequencer
    import sg_pkg::*;
#(
    parameter int C_MAX_READ_WORDS = 128,
    parameter int C_BOUNDARY_WORDS = 1024
) (
    input  logic                    CLK,
    input  logic                    RST_N,
    input  logic                    START,
    input  logic [SG_LEN_W-1:0]     XFER_LEN,
    input  logic                    ABORT,
    output logic                    BUSY,
    output logic                    DONE,
    output logic [SG_LEN_W-1:0]     WORDS_REQD,
    input  logic                    SG_VALID,
    input  logic                    SG_EMPTY,
    output logic                    SG_REN,
    input  logic [SG_ADDR_W-1:0]    SG_ADDR,
    input  logic [SG_LEN_W-1:0]     SG_LEN,
    output logic                    REQ,
    input  logic                    REQ_ACK,
    output logic [SG_ADDR_W-1:0]    REQ_ADDR,
    output logic [SG_REQ_LEN_W-1:0] REQ_LEN
);

    sg_state_t state_reg, state_next;

    logic [SG_ADDR_W-1:0]    addr_reg,     addr_next;
    logic [SG_LEN_W-1:0]     elem_rem_reg, elem_rem_next;
    logic [SG_LEN_W-1:0]     xfer_rem_reg, xfer_rem_next;
    logic [SG_LEN_W-1:0]     words_reg,    words_next;
    logic [1:0]              guard_reg,    guard_next;
    logic                    sg_ren_reg,   sg_ren_next;
    logic                    req_reg,      req_next;
    logic                    done_reg,     done_next;
    logic                    busy_reg,     busy_next;
    logic [SG_ADDR_W-1:0]    req_addr_reg, req_addr_next;
    logic [SG_REQ_LEN_W-1:0] req_len_reg,  req_len_next;

    logic [SG_REQ_LEN_W-1:0] calc_len;
    logic [SG_LEN_W-1:0]     ack_len;
    logic [SG_LEN_W-1:0]     xfer_after;
    logic [SG_LEN_W-1:0]     elem_after;
    logic                    pop_now;
    logic                    ack_now;

    sg_req_len_calc #(
        .C_MAX_READ_WORDS (C_MAX_READ_WORDS),
        .C_BOUNDARY_WORDS (C_BOUNDARY_WORDS)
    ) u_len_calc (
        .addr     (addr_reg),
        .elem_rem (elem_rem_reg),
        .xfer_rem (xfer_rem_reg),
        .req_len  (calc_len)
    );

    // The reader keeps VALID high for one cycle after REN, so a pop starts a
    // two-cycle guard during which SG_VALID is not looked at. ABORT wins
    // over a pop so no element is consumed on the way to FIN.
    assign pop_now = (state_reg == ST_WAIT_ELEM) && (guard_reg == 2'd0) &&
                     SG_VALID && !ABORT;
    assign ack_now = (state_reg == ST_ISSUE) && req_reg && REQ_ACK;

    assign ack_len    = SG_LEN_W'(req_len_reg);
    assign xfer_after = xfer_rem_reg - ack_len;
    assign elem_after = elem_rem_reg - ack_len;

    // ---------------- state register ----------------
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (START) begin
                    state_next = (XFER_LEN == '0) ? ST_FIN : ST_WAIT_ELEM;
                end
            end
            ST_WAIT_ELEM: begin
                if (ABORT) begin
                    state_next = ST_FIN;
                end else if (pop_now && (SG_LEN != '0)) begin
                    state_next = ST_CALC;
                end
            end
            ST_CALC: begin
                state_next = ABORT ? ST_FIN : ST_ISSUE;
            end
            ST_ISSUE: begin
                if (ack_now) begin
                    if (xfer_after == '0) begin
                        state_next = ST_FIN;
                    end else if (elem_after == '0) begin
                        state_next = ST_WAIT_ELEM;
                    end else begin
                        state_next = ST_CALC;
                    end
                end
                if (ABORT) begin
                    state_next = ST_FIN;
                end
            end
            ST_FIN: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // ---------------- output / datapath next values ----------------
    always_comb begin
        addr_next     = addr_reg;
        elem_rem_next = elem_rem_reg;
        xfer_rem_next = xfer_rem_reg;
        words_next    = words_reg;
        guard_next    = (guard_reg != 2'd0) ? guard_reg - 2'd1 : 2'd0;
        sg_ren_next   = 1'b0;
        req_next      = req_reg;
        req_addr_next = req_addr_reg;
        req_len_next  = req_len_reg;
        done_next     = (state_next == ST_FIN);
        busy_next     = (state_next != ST_IDLE);

        case (state_reg)
            ST_IDLE: begin
                if (START) begin
                    xfer_rem_next = XFER_LEN;
                    words_next    = '0;
                end
            end
            ST_WAIT_ELEM: begin
                if (pop_now) begin
                    sg_ren_next   = 1'b1;
                    guard_next    = 2'd2;
                    addr_next     = {SG_ADDR[SG_ADDR_W-1:SG_WORD_SHIFT], {SG_WORD_SHIFT{1'b0}}};
                    elem_rem_next = SG_LEN;
                end
            end
            ST_CALC: begin
                if (!ABORT) begin
                    req_next      = 1'b1;
                    req_addr_next = addr_reg;
                    req_len_next  = calc_len;
                end
            end
            ST_ISSUE: begin
                // An ack in the same cycle as ABORT is still accounted for.
                if (ack_now) begin
                    req_next      = 1'b0;
                    addr_next     = addr_reg + (SG_ADDR_W'(req_len_reg) << SG_WORD_SHIFT);
                    elem_rem_next = elem_after;
                    xfer_rem_next = xfer_after;
                    words_next    = words_reg + ack_len;
                end
                if (ABORT) begin
                    req_next = 1'b0;
                end
            end
            default: begin
            end
        endcase
    end

    // ---------------- registered outputs and datapath ----------------
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            addr_reg     <= '0;
            elem_rem_reg <= '0;
            xfer_rem_reg <= '0;
            words_reg    <= '0;
            guard_reg    <= 2'd0;
            sg_ren_reg   <= 1'b0;
            req_reg      <= 1'b0;
            req_addr_reg <= '0;
            req_len_reg  <= '0;
            done_reg     <= 1'b0;
            busy_reg     <= 1'b0;
        end else begin
            addr_reg     <= addr_next;
            elem_rem_reg <= elem_rem_next;
            xfer_rem_reg <= xfer_rem_next;
            words_reg    <= words_next;
            guard_reg    <= guard_next;
            sg_ren_reg   <= sg_ren_next;
            req_reg      <= req_next;
            req_addr_reg <= req_addr_next;
            req_len_reg  <= req_len_next;
            done_reg     <= done_next;
            busy_reg     <= busy_next;
        end
    end

    assign BUSY       = busy_reg;
    assign DONE       = done_reg;
    assign WORDS_REQD = words_reg;
    assign SG_REN     = sg_ren_reg;
    assign REQ        = req_reg;
    assign REQ_ADDR   = req_addr_reg;
    assign REQ_LEN    = req_len_reg;

    // SG_EMPTY is informational: the sequencer waits on SG_VALID alone.
    logic unused_in;
    assign unused_in = ^{SG_EMPTY, SG_ADDR[SG_WORD_SHIFT-1:0]};

endmodule

// File: tb/tb_sg_read_req_sequencer.sv
// ---------------------------------------------------------------------------
// tb_sg_read_req_sequencer
// Directed bench for sg_read_req_sequencer with default parameters
// (max read 128 words, 4 KB boundary). A small SG reader model presents
// queued elements and drops VALID one cycle after seeing REN.
// ---------------------------------------------------------------------------
module tb_sg_read_req_sequencer;

    logic        CLK;
    logic        RST_N;
    logic        START;
    logic [31:0] XFER_LEN;
    logic        ABORT;
    logic        BUSY;
    logic        DONE;
    logic [31:0] WORDS_REQD;
    logic        SG_VALID;
    logic        SG_EMPTY;
    logic        SG_REN;
    logic [63:0] SG_ADDR;
    logic [31:0] SG_LEN;
    logic        REQ;
    logic        REQ_ACK;
    logic [63:0] REQ_ADDR;
    logic [9:0]  REQ_LEN;

    int total  = 0;
    int passed = 0;
    int fails  = 0;

    // SG reader model: the initial block fills the element table and moves
    // wr_ptr; the negedge process below owns rd_ptr and the REN counter.
    logic [63:0] elem_addr [16];
    logic [31:0] elem_len  [16];
    logic [3:0]  wr_ptr = 4'd0;
    logic [3:0]  rd_ptr = 4'd0;
    logic        ren_d  = 1'b0;
    int          ren_cnt = 0;
    int          ren_base;

    assign SG_VALID = (rd_ptr != wr_ptr);
    assign SG_EMPTY = !SG_VALID;
    assign SG_ADDR  = elem_addr[rd_ptr];
    assign SG_LEN   = elem_len[rd_ptr];

    always @(negedge CLK) begin
        if (ren_d) rd_ptr <= rd_ptr + 4'd1;
        ren_d <= SG_REN;
        if (SG_REN) ren_cnt <= ren_cnt + 1;
    end

    sg_read_req_sequencer #(
        .C_MAX_READ_WORDS (128),
        .C_BOUNDARY_WORDS (1024)
    ) dut (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .START      (START),
        .XFER_LEN   (XFER_LEN),
        .ABORT      (ABORT),
        .BUSY       (BUSY),
        .DONE       (DONE),
        .WORDS_REQD (WORDS_REQD),
        .SG_VALID   (SG_VALID),
        .SG_EMPTY   (SG_EMPTY),
        .SG_REN     (SG_REN),
        .SG_ADDR    (SG_ADDR),
        .SG_LEN     (SG_LEN),
        .REQ        (REQ),
        .REQ_ACK    (REQ_ACK),
        .REQ_ADDR   (REQ_ADDR),
        .REQ_LEN    (REQ_LEN)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push_elem(input logic [63:0] a, input logic [31:0] l);
        elem_addr[wr_ptr] = a;
        elem_len[wr_ptr]  = l;
        wr_ptr = wr_ptr + 4'd1;
    endtask

    task automatic start_xfer(input logic [31:0] len);
        ren_base = ren_cnt;
        XFER_LEN = len;
        START    = 1'b1;
        @(negedge CLK);
        START    = 1'b0;
        $display("start xfer_len=%0d busy=%0b", len, BUSY);
    endtask

    // Wait for a request, check it, optionally hold off the ack, then ack.
    task automatic take_req(input string tag, input logic [63:0] a, input logic [9:0] l,
                            input int hold, input logic with_abort);
        int   n = 0;
        logic stable = 1'b1;
        while (REQ !== 1'b1 && n < 300) begin
            @(negedge CLK);
            n++;
        end
        $display("req %s addr=0x%0h len=%0d", tag, REQ_ADDR, REQ_LEN);
        chk({tag, "_req"}, 64'(REQ), 64'd1);
        chk({tag, "_addr"}, REQ_ADDR, a);
        chk({tag, "_len"}, 64'(REQ_LEN), 64'(l));
        for (int i = 0; i < hold; i++) begin
            @(negedge CLK);
            if (REQ !== 1'b1 || REQ_ADDR !== a || REQ_LEN !== l) stable = 1'b0;
        end
        if (hold > 0) chk({tag, "_stable"}, 64'(stable), 64'd1);
        REQ_ACK = 1'b1;
        ABORT   = with_abort;
        @(negedge CLK);
        REQ_ACK = 1'b0;
        ABORT   = 1'b0;
        chk({tag, "_drop"}, 64'(REQ), 64'd0);
    endtask

    task automatic wait_done(input string tag, input logic [31:0] words, input int rens);
        int n = 0;
        while (DONE !== 1'b1 && n < 300) begin
            @(negedge CLK);
            n++;
        end
        $display("done %s words=%0d rens=%0d", tag, WORDS_REQD, ren_cnt - ren_base);
        chk({tag, "_done"}, 64'(DONE), 64'd1);
        chk({tag, "_busy_fin"}, 64'(BUSY), 64'd1);
        chk({tag, "_words"}, 64'(WORDS_REQD), 64'(words));
        chk({tag, "_rens"}, 64'(ren_cnt - ren_base), 64'(rens));
        @(negedge CLK);
        chk({tag, "_done_pulse"}, 64'(DONE), 64'd0);
        chk({tag, "_idle"}, 64'(BUSY), 64'd0);
    endtask

    initial begin
        RST_N    = 1'b1;
        START    = 1'b0;
        XFER_LEN = 32'd0;
        ABORT    = 1'b0;
        REQ_ACK  = 1'b0;

        // Reset state
        #1 RST_N = 1'b0;
        #2;
        chk("rst_busy", 64'(BUSY), 64'd0);
        chk("rst_done", 64'(DONE), 64'd0);
        chk("rst_ren", 64'(SG_REN), 64'd0);
        chk("rst_req", 64'(REQ), 64'd0);
        chk("rst_req_addr", REQ_ADDR, 64'd0);
        chk("rst_req_len", 64'(REQ_LEN), 64'd0);
        chk("rst_words", 64'(WORDS_REQD), 64'd0);
        repeat (2) @(negedge CLK);
        RST_N = 1'b1;
        @(negedge CLK);

        // Single aligned element split by max read size
        push_elem(64'h1000, 32'd300);
        start_xfer(32'd300);
        chk("t1_busy", 64'(BUSY), 64'd1);
        take_req("t1_r0", 64'h1000, 10'd128, 0, 1'b0);
        take_req("t1_r1", 64'h1200, 10'd128, 0, 1'b0);
        take_req("t1_r2", 64'h1400, 10'd44, 0, 1'b0);
        wait_done("t1", 32'd300, 1);

        // 4 KB boundary crossing; low address bits are dropped
        push_elem(64'h0FF2, 32'd64);
        start_xfer(32'd64);
        take_req("t2_r0", 64'h0FF0, 10'd4, 0, 1'b0);
        take_req("t2_r1", 64'h1000, 10'd60, 0, 1'b0);
        wait_done("t2", 32'd64, 1);

        // Transfer ends inside the second element
        push_elem(64'h2000, 32'd10);
        push_elem(64'h8000, 32'd10);
        start_xfer(32'd15);
        take_req("t3_r0", 64'h2000, 10'd10, 0, 1'b0);
        take_req("t3_r1", 64'h8000, 10'd5, 0, 1'b0);
        wait_done("t3", 32'd15, 2);

        // Zero-length element is popped and skipped
        push_elem(64'h5000, 32'd0);
        push_elem(64'h3000, 32'd8);
        start_xfer(32'd8);
        take_req("t4_r0", 64'h3000, 10'd8, 0, 1'b0);
        wait_done("t4", 32'd8, 2);

        // Zero transfer length goes straight to DONE
        start_xfer(32'd0);
        wait_done("t5", 32'd0, 0);

        // Held-off ack, then ABORT together with REQ_ACK
        push_elem(64'h6000, 32'd200);
        start_xfer(32'd300);
        take_req("t6_r0", 64'h6000, 10'd128, 5, 1'b0);
        take_req("t6_r1", 64'h6200, 10'd72, 0, 1'b1);
        wait_done("t6", 32'd200, 1);

        // Asynchronous reset during ISSUE, then a normal transfer
        push_elem(64'h7000, 32'd50);
        start_xfer(32'd50);
        begin
            int n = 0;
            while (REQ !== 1'b1 && n < 300) begin
                @(negedge CLK);
                n++;
            end
        end
        chk("t7_req_before", 64'(REQ), 64'd1);
        #2 RST_N = 1'b0;
        #1;
        $display("async reset req=%0b busy=%0b ren=%0b", REQ, BUSY, SG_REN);
        chk("t7_req_async", 64'(REQ), 64'd0);
        chk("t7_busy_async", 64'(BUSY), 64'd0);
        chk("t7_ren_async", 64'(SG_REN), 64'd0);
        chk("t7_done_async", 64'(DONE), 64'd0);
        chk("t7_words_async", 64'(WORDS_REQD), 64'd0);
        @(negedge CLK);
        RST_N = 1'b1;
        @(negedge CLK);
        push_elem(64'h9000, 32'd16);
        start_xfer(32'd16);
        take_req("t7_r0", 64'h9000, 10'd16, 0, 1'b0);
        wait_done("t7", 32'd16, 1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
